// File: rtl/rgb_pkg.sv
// Shared colour tables for the RGB LED decoder/encoder pair and the encoder FSM encoding.
// Both directions import these constants, so the two mappings stay in step.
package rgb_pkg;

  // Colour codes
  localparam logic [2:0] RED     = 3'd0;
  localparam logic [2:0] MAGENTA = 3'd1;
  localparam logic [2:0] YELLOW  = 3'd2;
  localparam logic [2:0] GREEN   = 3'd3;
  localparam logic [2:0] CYAN    = 3'd4;
  localparam logic [2:0] BLUE    = 3'd5;
  localparam logic [2:0] WHITE   = 3'd6;
  localparam logic [2:0] OFF     = 3'd7;

  // One LED's {R,G,B} drive pattern for each colour
  localparam logic [2:0] PAT_RED     = 3'b100;
  localparam logic [2:0] PAT_MAGENTA = 3'b101;
  localparam logic [2:0] PAT_YELLOW  = 3'b110;
  localparam logic [2:0] PAT_GREEN   = 3'b010;
  localparam logic [2:0] PAT_CYAN    = 3'b011;
  localparam logic [2:0] PAT_BLUE    = 3'b001;
  localparam logic [2:0] PAT_WHITE   = 3'b111;
  localparam logic [2:0] PAT_OFF     = 3'b000;

  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/rgb_half_enc.sv
// Combinational encoder: one LED's 3-bit {R,G,B} pattern -> 3-bit colour code.
module rgb_half_enc
  import rgb_pkg::*;
(
  input  logic [2:0] pat,
  output logic [2:0] code
);

  // NOTE: assigning a default before the case keeps this purely combinational (no latch).
  always_comb begin
    code = OFF;
    case (pat)
      PAT_RED:     code = RED;
      PAT_MAGENTA: code = MAGENTA;
      PAT_YELLOW:  code = YELLOW;
      PAT_GREEN:   code = GREEN;
      PAT_CYAN:    code = CYAN;
      PAT_BLUE:    code = BLUE;
      PAT_WHITE:   code = WHITE;
      PAT_OFF:     code = OFF;
      default:     code = OFF;
    endcase
  end

endmodule

// File: rtl/rgb_encoder.sv
// Recovers the colour code from the two-LED drive pattern: synchronise, debounce,
// consistency-check, then hand each new stable pattern downstream once via valid/ready.
module rgb_encoder
  import rgb_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] rgb_in,
  output logic [2:0] out_code,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [5:0]       sync1, rgb_s;
  logic [5:0]       last_pat, cand, cand_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  state_t           state, state_d;
  logic             emit, accept;
  logic [2:0]       half_code;
  logic             consistent;

  rgb_half_enc u_half_enc (
    .pat  (cand[5:3]),
    .code (half_code)
  );

  assign consistent = (cand[5:3] == cand[2:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      rgb_s <= '0;
    end else begin
      sync1 <= rgb_in;
      rgb_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    emit    = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (rgb_s != last_pat) begin
          cand_d  = rgb_s;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // A glitch that returns to the last emitted pattern is dropped silently.
        if (rgb_s == last_pat) begin
          state_d = IDLE;
        end else if (rgb_s != cand) begin
          cand_d = rgb_s;
          cnt_d  = CNT_ONE;
        end else if (cnt < STABLE_N) begin
          cnt_d = cnt + CNT_ONE;
        end else begin
          emit    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '0;
      cnt       <= '0;
      last_pat  <= '0;
      out_code  <= OFF;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      err_count <= '0;
    end else begin
      cand <= cand_d;
      cnt  <= cnt_d;
      if (emit) begin
        out_code  <= consistent ? half_code : OFF;
        out_err   <= !consistent;
        out_valid <= 1'b1;
        last_pat  <= cand;
        if (!consistent && err_count != ERR_MAX) err_count <= err_count + 8'd1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_encoder.sv
// Self-checking bench for rgb_encoder: directed scenarios plus random patterns scored
// against a table-driven reference of the colour mapping and consistency rule.
module tb_rgb_encoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] rgb_in;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_err;
  logic       out_valid;
  logic [7:0] err_count;

  int         total = 0;
  int         bad   = 0;
  int         enc_tab [8];
  int         ref_err = 0;
  logic [5:0] last_emit = 6'b000000;

  rgb_encoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rgb_in    (rgb_in),
    .out_code  (out_code),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns {err, code} for a 6-bit LED pattern
  function automatic logic [3:0] model(input logic [5:0] p);
    if (p[5:3] == p[2:0]) return {1'b0, 3'(enc_tab[p[5:3]])};
    return {1'b1, 3'd7};
  endfunction

  function automatic logic [5:0] pick(input bit want_err);
    logic [5:0] p;
    do p = 6'($urandom_range(0, 63));
    while (((p[5:3] != p[2:0]) != want_err) || (p == last_emit));
    return p;
  endfunction

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Apply a clean new pattern, expect one emit, hold it for `hold` cycles, then accept.
  task automatic run_pat(input string tag, input logic [5:0] pat, input int hold);
    logic [3:0] m;
    int         n;
    logic       stable;
    m = model(pat);
    if (m[3] && ref_err < 255) ref_err++;
    @(negedge clk);
    rgb_in    = pat;
    out_ready = (hold == 0);
    wait_valid(n);
    check({tag, "_latency"}, n, 3 + STABLE);
    check({tag, "_code"}, out_code, m[2:0]);
    check({tag, "_err"}, out_err, m[3]);
    check({tag, "_err_count"}, err_count, ref_err);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_code !== m[2:0]) stable = 1'b0;
    end
    check({tag, "_hold_stable"}, stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    last_emit = pat;
  endtask

  initial begin
    int         n;
    logic       seen;
    logic [5:0] sweep [8];

    enc_tab[3'b100] = 0; enc_tab[3'b101] = 1; enc_tab[3'b110] = 2; enc_tab[3'b010] = 3;
    enc_tab[3'b011] = 4; enc_tab[3'b001] = 5; enc_tab[3'b111] = 6; enc_tab[3'b000] = 7;
    sweep = '{6'b100100, 6'b101101, 6'b110110, 6'b010010,
              6'b011011, 6'b001001, 6'b111111, 6'b000000};

    rst_n = 1'b0; rgb_in = 6'b000000; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_code", out_code, 7);
    check("rst_err", out_err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;

    // Off pattern right after reset must never be emitted
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
    check("off_no_emit", seen, 0);
    check("off_code", out_code, 7);
    check("off_err_count", err_count, 0);

    // Two-cycle glitch that returns to the previous pattern
    @(negedge clk); rgb_in = 6'b111111;
    repeat (2) @(negedge clk);
    rgb_in = 6'b000000;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
    check("glitch_no_emit", seen, 0);

    run_pat("white", 6'b111111, 0);
    run_pat("cyan", 6'b011011, 0);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
    check("cyan_no_repeat", seen, 0);

    run_pat("err1", 6'b100101, 0);
    check("err1_count", err_count, 1);

    for (int k = 0; k < 24; k++)
      run_pat("rand", pick(1'($urandom_range(0, 1))), int'($urandom_range(0, 3)));

    while (ref_err < 255) run_pat("sat", pick(1'b1), 0);
    repeat (3) run_pat("sat_hold", pick(1'b1), 0);
    check("sat_err_count", err_count, 255);

    // Backpressure: input changes during HOLD are deferred until after the handshake
    @(negedge clk); rgb_in = 6'b010010; out_ready = 1'b0;
    wait_valid(n);
    check("bp_latency", n, 3 + STABLE);
    check("bp_code", out_code, 3);
    @(negedge clk); rgb_in = 6'b001001;
    seen = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_code !== 3'd3) seen = 1'b0;
    end
    check("bp_hold_stable", seen, 1);
    out_ready = 1'b1;
    wait_valid(n);
    check("bp_next_latency", n, STABLE + 2);
    check("bp_next_code", out_code, 5);
    check("bp_next_err", out_err, 0);
    @(negedge clk);
    check("bp_next_drop", out_valid, 0);
    last_emit = 6'b001001;

    for (int i = 0; i < 8; i++) begin
      run_pat("sweep", sweep[i], int'($urandom_range(0, 2)));
      check("sweep_table", out_code, i);
    end

    // Asynchronous reset while an unaccepted result is held
    @(negedge clk); rgb_in = 6'b101101; out_ready = 1'b0;
    wait_valid(n);
    check("arst_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_code", out_code, 7);
    check("arst_err", out_err, 0);
    check("arst_err_count", err_count, 0);
    @(negedge clk);
    rgb_in = 6'b000000; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
    check("arst_off_no_emit", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
